wb_rr_arbiter: RTL and testbench

Parametrised Wishbone-classic arbiter that connects N_MASTER bus masters (core IF, core MEM, debug module, future DMA) to a single slave port. It replaces fixed-topology master wiring in the SoC top. Features: selectable round-robin or fixed-priority arbitration, bus locking for the full `cyc` duration, and a watchdog that answers hung slaves with an error.

---
 rtl/wb_rr_arbiter_pkg.sv | 19 +
 rtl/wb_rr_arbiter_if.sv | 45 ++++
 rtl/wb_rr_arbiter_prio_enc.sv | 33 +++
 rtl/wb_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  // Width of the watchdog counter. It is never narrower than one bit, so a
  // disabled watchdog (timeout 0) still has a legal declaration.
  function automatic int wd_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of Wishbone master-side and slave-side signals around the arbiter.
// The 'slave' modport is the arbiter's own view: it is the slave of the
// requesting masters and it drives the shared slave port. The 'master'
// modport is the surrounding system, which drives the requests and the
// slave responses.
interface wb_rr_arbiter_if #(
  parameter int N_MASTER = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);
  logic [N_MASTER-1:0]            m_cyc_i;
  logic [N_MASTER-1:0]            m_stb_i;
  logic [N_MASTER-1:0]            m_we_i;
  logic [N_MASTER*ADDR_W-1:0]     m_adr_i;
  logic [N_MASTER*DATA_W-1:0]     m_dat_i;
  logic [N_MASTER*DATA_W/8-1:0]   m_sel_i;
  logic [DATA_W-1:0]              m_dat_o;
  logic [N_MASTER-1:0]            m_ack_o;
  logic [N_MASTER-1:0]            m_err_o;

  logic                           s_cyc_o;
  logic                           s_stb_o;
  logic                           s_we_o;
  logic [ADDR_W-1:0]              s_adr_o;
  logic [DATA_W-1:0]              s_dat_o;
  logic [DATA_W/8-1:0]            s_sel_o;
  logic [DATA_W-1:0]              s_dat_i;
  logic                           s_ack_i;
  logic                           s_err_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i, s_err_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i, s_err_i
  );

endinterface

// File: rtl/wb_rr_arbiter_prio_enc.sv
// Rotating priority encoder: scans the request vector starting at ptr_i,
// wrapping modulo N, and returns the first requester as one-hot and index.
module rr_prio_enc #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // First set request at or after the pointer wins; nothing set means no grant.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      int               j;
      logic [IDX_W-1:0] jj;
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      jj = IDX_W'(j);
      if (!valid_o && req_i[jj]) begin
        valid_o   = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone-classic N-to-1 arbiter with round-robin or fixed priority,
// cycle-long bus locking and a watchdog that errors out hung slaves.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTER = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RR_MODE  = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rstn_i,
  wb_rr_arbiter_if.slave      bus,
  output logic [N_MASTER-1:0] grant_o,
  output logic                busy_o
);

  localparam int IDX_W = $clog2(N_MASTER);
  localparam int WD_W  = wd_width(TIMEOUT);
  localparam int SEL_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic [N_MASTER-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;

  logic [IDX_W-1:0]    enc_ptr;
  logic [IDX_W-1:0]    enc_idx;
  logic [N_MASTER-1:0] enc_gnt;
  logic                enc_valid;

  logic [ADDR_W-1:0]   adr_a [N_MASTER];
  logic [DATA_W-1:0]   dat_a [N_MASTER];
  logic [SEL_W-1:0]    sel_a [N_MASTER];

  logic                owner_cyc;
  logic                live;
  logic                release_w;
  logic                wd_count;
  logic                wd_fire;
  logic [IDX_W-1:0]    next_ptr;

  // Fixed-priority mode pins the search start to master 0.
  assign enc_ptr = (RR_MODE != 0) ? rr_ptr_q : '0;

  rr_prio_enc #(
    .N     (N_MASTER),
    .IDX_W (IDX_W)
  ) u_enc (
    .ptr_i   (enc_ptr),
    .req_i   (bus.m_cyc_i),
    .gnt_o   (enc_gnt),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  // Slice the packed per-master buses into arrays so the owner can be picked by index.
  for (genvar i = 0; i < N_MASTER; i++) begin : g_unpack
    assign adr_a[i] = bus.m_adr_i[i*ADDR_W +: ADDR_W];
    assign dat_a[i] = bus.m_dat_i[i*DATA_W +: DATA_W];
    assign sel_a[i] = bus.m_sel_i[i*SEL_W +: SEL_W];
  end

  // The slave only sees the owner while it is in OWN and still holds cyc,
  // so a dropped cyc cuts the slave off in the same cycle.
  assign owner_cyc = bus.m_cyc_i[idx_q];
  assign live      = (state_q == OWN) && owner_cyc;
  assign release_w = (state_q != IDLE) && !owner_cyc;
  assign next_ptr  = (idx_q == IDX_W'(N_MASTER - 1)) ? '0 : idx_q + 1'b1;

  assign bus.s_cyc_o = live;
  assign bus.s_stb_o = live && bus.m_stb_i[idx_q];
  assign bus.s_we_o  = live && bus.m_we_i[idx_q];
  assign bus.s_adr_o = live ? adr_a[idx_q] : '0;
  assign bus.s_dat_o = live ? dat_a[idx_q] : '0;
  assign bus.s_sel_o = live ? sel_a[idx_q] : '0;

  // Read data is broadcast, but held at zero outside OWN.
  assign bus.m_dat_o = (state_q == OWN) ? bus.s_dat_i : '0;

  // The watchdog counts strobed cycles the slave leaves unanswered and
  // fires on the last one before the limit.
  assign wd_count = (TIMEOUT != 0) && bus.s_stb_o && !bus.s_ack_i && !bus.s_err_i;
  assign wd_fire  = wd_count && (wd_cnt_q == WD_W'(TIMEOUT - 1));

  // Responses are steered to the owner only; everyone else sees silence.
  for (genvar i = 0; i < N_MASTER; i++) begin : g_demux
    assign bus.m_ack_o[i] = grant_q[i] && live && bus.s_ack_i;
    assign bus.m_err_o[i] = grant_q[i] && ((live && bus.s_err_i) || wd_fire);
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

  // Next-state logic: arbitrate in IDLE, hold ownership while cyc stays up,
  // and bail out to ABORT when the watchdog fires.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    wd_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d = OWN;
          grant_d = enc_gnt;
          idx_d   = enc_idx;
        end
      end
      OWN: begin
        if (wd_fire) begin
          state_d = ABORT;
        end else if (wd_count) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      ABORT: begin
        state_d = ABORT;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (release_w) begin
      state_d  = IDLE;
      grant_d  = '0;
      rr_ptr_d = next_ptr;
      wd_cnt_d = '0;
    end
  end

  // State registers, cleared asynchronously so outputs drop without a clock.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a vector table for single transactions
// plus hand-written sequences for fairness, priority, lock, watchdog and reset.
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] SDAT = 32'h1234_5678;

  logic clk = 1'b0;
  logic rstn_i;
  logic [N-1:0] grant0, grant1;
  logic busy0, busy1;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.N_MASTER(N), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
  wb_rr_arbiter_if #(.N_MASTER(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();

  wb_rr_arbiter #(.N_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(8)) dut0 (
    .clk(clk), .rstn_i(rstn_i), .bus(bus0.slave), .grant_o(grant0), .busy_o(busy0));

  wb_rr_arbiter #(.N_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(0)) dut1 (
    .clk(clk), .rstn_i(rstn_i), .bus(bus1.slave), .grant_o(grant1), .busy_o(busy1));

  typedef struct {
    logic [2:0] cyc;
    logic [2:0] stb;
    logic       ack;
    logic       err;
    logic [2:0] grant;
    logic [2:0] mack;
    logic [2:0] merr;
    logic       busy;
    logic       scyc;
    logic       sstb;
    logic       swe;
    logic [31:0] sadr;
    logic       dat;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ctrl0();
    return {grant0, bus0.m_ack_o, bus0.m_err_o, busy0, bus0.s_cyc_o, bus0.s_stb_o};
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus0.m_cyc_i = v.cyc;
    bus0.m_stb_i = v.stb;
    bus0.s_ack_i = v.ack;
    bus0.s_err_i = v.err;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] bench did not finish");
  end

  initial begin
    // m0 at 0x100, m1 at 0x10, m2 at 0x200 (m2 writes)
    bus0.m_cyc_i = '0; bus0.m_stb_i = '0; bus0.m_we_i = 3'b100;
    bus0.m_adr_i = {32'h200, 32'h10, 32'h100};
    bus0.m_dat_i = {32'hA2, 32'hA1, 32'hA0};
    bus0.m_sel_i = '1;
    bus0.s_dat_i = SDAT; bus0.s_ack_i = 1'b0; bus0.s_err_i = 1'b0;
    bus1.m_cyc_i = '0; bus1.m_stb_i = '0; bus1.m_we_i = '0;
    bus1.m_adr_i = {32'h200, 32'h10, 32'h100};
    bus1.m_dat_i = {32'hB2, 32'hB1, 32'hB0};
    bus1.m_sel_i = '1;
    bus1.s_dat_i = SDAT; bus1.s_ack_i = 1'b0; bus1.s_err_i = 1'b0;

    //           cyc     stb     ack  err   grant   mack    merr  busy scyc sstb swe sadr    dat
    vecs[0]  = '{3'b010, 3'b010, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0};
    vecs[1]  = '{3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10,  1'b1};
    vecs[2]  = '{3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10,  1'b1};
    vecs[3]  = '{3'b010, 3'b010, 1'b1, 1'b0, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10,  1'b1};
    vecs[4]  = '{3'b001, 3'b001, 1'b1, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1};
    vecs[5]  = '{3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0};
    vecs[6]  = '{3'b101, 3'b101, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1};
    vecs[7]  = '{3'b101, 3'b101, 1'b1, 1'b0, 3'b001, 3'b001, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1};
    vecs[8]  = '{3'b101, 3'b101, 1'b0, 1'b1, 3'b001, 3'b000, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1};
    vecs[9]  = '{3'b100, 3'b100, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1};
    vecs[10] = '{3'b100, 3'b100, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0};
    vecs[11] = '{3'b100, 3'b100, 1'b1, 1'b0, 3'b100, 3'b100, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1};
    vecs[12] = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1};
    vecs[13] = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0};

    // Reset state
    rstn_i = 1'b0;
    #12;
    checkOutput("reset ctrl0", {ctrl0(), bus0.s_we_o}, 13'h0);
    checkOutput("reset data0", {bus0.s_adr_o, bus0.m_dat_o}, 64'h0);
    checkOutput("reset ctrl1", {grant1, busy1, bus1.s_cyc_o, bus1.m_dat_o}, 64'h0);
    rstn_i = 1'b1;
    tick();

    // Table-driven single transactions on the round-robin instance
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d ctrl", i), {ctrl0(), bus0.s_we_o},
                  {vecs[i].grant, vecs[i].mack, vecs[i].merr, vecs[i].busy,
                   vecs[i].scyc, vecs[i].sstb, vecs[i].swe});
      checkOutput($sformatf("vec%0d s_adr", i), bus0.s_adr_o, vecs[i].sadr);
      checkOutput($sformatf("vec%0d m_dat", i), bus0.m_dat_o, vecs[i].dat ? SDAT : 32'h0);
      tick();
    end
    bus0.s_ack_i = 1'b0;
    bus0.s_err_i = 1'b0;
    bus0.m_we_i  = 3'b000;

    // Round-robin fairness: everyone requests, grantee drops after its ack
    bus0.m_cyc_i = 3'b111;
    bus0.m_stb_i = 3'b111;
    for (int r = 0; r < 6; r++) begin
      int n;
      logic [2:0] expG;
      expG = 3'(1 << (r % 3));
      n = 0;
      @(negedge clk);
      while (grant0 == 3'b000 && n < 4) begin
        tick();
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("rr round%0d grant", r), grant0, expG);
      bus0.s_ack_i = 1'b1;
      #1;
      checkOutput($sformatf("rr round%0d ack", r), bus0.m_ack_o, expG);
      tick();
      bus0.s_ack_i = 1'b0;
      bus0.m_cyc_i = bus0.m_cyc_i & ~grant0;
      tick();
      bus0.m_cyc_i = 3'b111;
    end
    bus0.m_cyc_i = 3'b000;
    bus0.m_stb_i = 3'b000;

    // Fixed priority: m0 keeps winning while it re-requests, then m1
    bus1.m_cyc_i = 3'b111;
    bus1.m_stb_i = 3'b111;
    for (int r = 0; r < 5; r++) begin
      int n;
      logic [2:0] expG;
      expG = (r < 4) ? 3'b001 : 3'b010;
      n = 0;
      @(negedge clk);
      while (grant1 == 3'b000 && n < 4) begin
        tick();
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("fp round%0d grant", r), grant1, expG);
      bus1.s_ack_i = 1'b1;
      #1;
      checkOutput($sformatf("fp round%0d ack", r), bus1.m_ack_o, expG);
      tick();
      bus1.s_ack_i = 1'b0;
      bus1.m_cyc_i = bus1.m_cyc_i & ~grant1;
      tick();
      bus1.m_cyc_i = (r < 3) ? 3'b111 : 3'b110;
    end
    bus1.m_cyc_i = 3'b000;
    bus1.m_stb_i = 3'b000;

    // Lock: m2 bursts four beats while m0 waits
    tick();
    bus0.m_cyc_i = 3'b100;
    bus0.m_stb_i = 3'b100;
    tick();
    bus0.m_cyc_i = 3'b101;
    bus0.m_stb_i = 3'b101;
    for (int b = 0; b < 4; b++) begin
      bus0.s_ack_i = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("lock beat%0d grant/ack", b), {grant0, bus0.m_ack_o}, {3'b100, 3'b100});
      tick();
    end
    bus0.s_ack_i = 1'b0;
    bus0.m_cyc_i = 3'b001;
    bus0.m_stb_i = 3'b001;
    @(negedge clk);
    checkOutput("lock drop cycle", {grant0, bus0.s_cyc_o}, {3'b100, 1'b0});
    tick();
    @(negedge clk);
    checkOutput("lock idle gap", {grant0, busy0}, {3'b000, 1'b0});
    tick();
    @(negedge clk);
    checkOutput("lock m0 granted", {grant0, bus0.s_cyc_o}, {3'b001, 1'b1});
    bus0.m_cyc_i = 3'b000;
    bus0.m_stb_i = 3'b000;
    tick();
    tick();

    // Watchdog: m1 strobes, slave never answers
    bus0.m_cyc_i = 3'b010;
    bus0.m_stb_i = 3'b010;
    tick();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("wd stb cycle%0d err", i), {grant0, bus0.m_err_o},
                  {3'b010, (i == 8) ? 3'b010 : 3'b000});
      tick();
    end
    bus0.s_ack_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("wd abort%0d", i), ctrl0(), {3'b010, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0});
      tick();
    end
    bus0.s_ack_i = 1'b0;
    bus0.m_cyc_i = 3'b000;
    bus0.m_stb_i = 3'b000;
    #1;
    checkOutput("wd abort until edge", {grant0, busy0}, {3'b010, 1'b1});
    tick();
    @(negedge clk);
    checkOutput("wd back to idle", {grant0, busy0}, {3'b000, 1'b0});
    tick();

    // Reset mid-transaction, then first grant goes to m0
    bus0.m_cyc_i = 3'b010;
    bus0.m_stb_i = 3'b010;
    tick();
    bus0.s_ack_i = 1'b1;
    @(negedge clk);
    checkOutput("pre-reset ack", {grant0, bus0.m_ack_o}, {3'b010, 3'b010});
    #2;
    rstn_i = 1'b0;
    #1;
    checkOutput("async reset ctrl", {ctrl0(), bus0.s_we_o}, 13'h0);
    checkOutput("async reset data", {bus0.s_adr_o, bus0.m_dat_o}, 64'h0);
    tick();
    bus0.s_ack_i = 1'b0;
    bus0.m_cyc_i = 3'b111;
    bus0.m_stb_i = 3'b111;
    rstn_i = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("post-reset grant", grant0, 3'b001);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
